// File: rtl/fb_pkg.sv
// fb_pkg: shared types and address helper for the framebuffer access scheduler
package fb_pkg;
  localparam int RGB_W = 3;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic int fb_addr(input int x, input int y, input int res_h);
    return y * res_h + x;
  endfunction
endpackage

// File: rtl/fb_clear_sweeper.sv
// fb_clear_sweeper: linear address counter that walks the framebuffer for the clear engine
module fb_clear_sweeper #(
  parameter int DEPTH = 307200,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] count,
  output logic              done
);
  assign done = count == ADDR_W'(DEPTH - 1);
  // restart on start, advance on each clear write, wrap after the last pixel
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (start) count <= '0;
    else if (step) count <= done ? '0 : count + 1'b1;
endmodule

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler: shares one framebuffer RAM between scanout, clear engine and brush (FB_CLEAR_ON_RESET_EN starts a clear after reset)
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480,
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter logic [RGB_W-1:0] CLEAR_COLOR = 3'b000,
  localparam int ADDR_W = $clog2(RESOLUTION_H * RESOLUTION_V)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_en,
  input  logic                  display_on,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  output logic [RGB_W-1:0]      pix_rgb,
  input  logic                  wr_req,
  input  logic [HPOS_WIDTH-1:0] wr_x,
  input  logic [VPOS_WIDTH-1:0] wr_y,
  input  logic [RGB_W-1:0]      wr_rgb,
  output logic                  wr_ack,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [RGB_W-1:0]      mem_wdata,
  input  logic [RGB_W-1:0]      mem_rdata
);
  state_t state;
  logic boot, ack_q, rd_vld, rd_on, done;
  logic scan, in_range, go_clear, clr_wr, br, br_wr;
  logic [ADDR_W-1:0] addr_q, count, scan_addr, br_addr;
  assign scan      = pix_en && display_on;
  assign scan_addr = ADDR_W'(fb_addr(int'(hpos), int'(vpos), RESOLUTION_H));
  assign br_addr   = ADDR_W'(fb_addr(int'(wr_x), int'(wr_y), RESOLUTION_H));
  assign in_range  = int'(wr_x) < RESOLUTION_H && int'(wr_y) < RESOLUTION_V;
  assign go_clear  = state == IDLE && (clear_req || boot);
  assign clr_wr    = state == CLEAR && !scan;
  // a request acked last cycle is not served again so one request never sees two acks
  assign br        = state == IDLE && !go_clear && !scan && wr_req && !ack_q;
  assign br_wr     = br && in_range;
  assign mem_we    = reset_n && (clr_wr || br_wr);
  assign wr_ack    = reset_n && br;
  assign mem_addr  = !reset_n ? '0 : scan ? scan_addr : clr_wr ? count : br_wr ? br_addr : addr_q;
  assign mem_wdata = !reset_n ? '0 : clr_wr ? CLEAR_COLOR : br_wr ? wr_rgb : '0;
  assign clear_busy = state == CLEAR;
`ifdef FB_CLEAR_ON_RESET_EN
  // one-shot flag that kicks off a clear on the first edge after reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) boot <= 1'b1;
    else boot <= 1'b0;
`else
  assign boot = 1'b0;
`endif
  fb_clear_sweeper #(.DEPTH(RESOLUTION_H * RESOLUTION_V), .ADDR_W(ADDR_W)) u_sweeper (
    .clk(clk), .reset_n(reset_n), .start(go_clear), .step(clr_wr), .count(count), .done(done)
  );
  // IDLE/CLEAR control: leave CLEAR once the last pixel has been written
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (go_clear) state <= CLEAR;
    else if (clr_wr && done) state <= IDLE;
  // address hold, ack history and the two-stage scanout read pipeline
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q  <= '0;
      ack_q   <= 1'b0;
      rd_vld  <= 1'b0;
      rd_on   <= 1'b0;
      pix_rgb <= '0;
    end else begin
      addr_q <= mem_addr;
      ack_q  <= wr_ack;
      rd_vld <= pix_en;
      rd_on  <= display_on;
      if (rd_vld) pix_rgb <= rd_on ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_fb_access_scheduler.sv
// tb_fb_access_scheduler: table vectors, corner sequences and random traffic against a cycle model
module tb_fb_access_scheduler;
  localparam int H = 8, V = 4, N = H * V, AW = 5;
  localparam logic [2:0] CC = 3'b010;
  logic clk = 0, reset_n = 1, pix_en = 0, display_on = 0, wr_req = 0, clear_req = 0;
  logic [9:0] hpos = 0, vpos = 0, wr_x = 0, wr_y = 0;
  logic [2:0] wr_rgb = 0, pix_rgb, mem_wdata, mem_rdata;
  logic wr_ack, clear_busy, mem_we;
  logic [AW-1:0] mem_addr;
  int checks = 0, errors = 0;
  logic [2:0] ram [N];
  logic [2:0] mram [N];
  bit m_busy, m_boot, m_last_ack, s1_v, e_we, e_ack, e_go, e_scan;
  int m_cnt, m_last_addr, e_addr;
  logic [2:0] s1_d, m_pix, e_wd;
  typedef struct {
    logic pe, don; int h, v; logic wr; int x, y; logic [2:0] rgb; logic cr;
    logic we, ack; int addr; logic pc; logic [2:0] pix;
  } vec_t;
  vec_t tv [14];

  always #5 clk = ~clk;

  fb_access_scheduler #(.RESOLUTION_H(H), .RESOLUTION_V(V), .HPOS_WIDTH(10), .VPOS_WIDTH(10),
    .CLEAR_COLOR(CC)) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .pix_rgb(pix_rgb), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .wr_ack(wr_ack),
    .clear_req(clear_req), .clear_busy(clear_busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_last_ack = 0; m_last_addr = 0; s1_v = 0; s1_d = 0; m_pix = 0;
`ifdef FB_CLEAR_ON_RESET_EN
    m_boot = 1;
`else
    m_boot = 0;
`endif
  endtask

  task automatic settle();
    #4;
    e_scan = pix_en && display_on;
    e_go = !m_busy && (clear_req || m_boot);
    e_we = 0; e_ack = 0; e_wd = 0; e_addr = m_last_addr;
    if (e_scan) e_addr = int'(vpos) * H + int'(hpos);
    else if (m_busy) begin e_we = 1; e_addr = m_cnt; e_wd = CC; end
    else if (!e_go && wr_req && !m_last_ack) begin
      e_ack = 1;
      if (int'(wr_x) < H && int'(wr_y) < V) begin
        e_we = 1; e_addr = int'(wr_y) * H + int'(wr_x); e_wd = wr_rgb;
      end
    end
    chk("we", mem_we, e_we);
    chk("ack", wr_ack, e_ack);
    chk("busy", clear_busy, m_busy);
    chk("pix", pix_rgb, m_pix);
    chk("addr", mem_addr, e_addr);
    if (e_we) chk("wdata", mem_wdata, e_wd);
  endtask

  task automatic advance();
    @(posedge clk);
    if (s1_v) m_pix = s1_d;
    s1_v = pix_en;
    s1_d = display_on ? mram[int'(vpos) * H + int'(hpos)] : 3'b000;
    if (e_we) mram[e_addr] = e_wd;
    if (e_go) begin m_busy = 1; m_cnt = 0; end
    else if (m_busy && !e_scan) begin
      if (m_cnt == N - 1) m_busy = 0; else m_cnt++;
    end
    m_boot = 0;
    m_last_ack = e_ack;
    m_last_addr = e_addr;
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    pix_en = 0; display_on = 0; wr_req = 0; clear_req = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_ack"}, wr_ack, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_pix"}, pix_rgb, 0);
  endtask

  initial begin
    tv[0]  = '{0,0,0,0, 1,3,2,3'd5, 0, 1,1,19, 0,3'd0};
    tv[1]  = '{0,0,0,0, 0,0,0,3'd0, 0, 0,0,19, 0,3'd0};
    tv[2]  = '{1,1,0,1, 1,5,1,3'd3, 0, 0,0,8,  0,3'd0};
    tv[3]  = '{1,1,1,1, 1,5,1,3'd3, 0, 0,0,9,  0,3'd0};
    tv[4]  = '{1,1,2,1, 1,5,1,3'd3, 0, 0,0,10, 0,3'd0};
    tv[5]  = '{1,1,3,1, 1,5,1,3'd3, 0, 0,0,11, 0,3'd0};
    tv[6]  = '{0,0,0,0, 1,5,1,3'd3, 0, 1,1,13, 0,3'd0};
    tv[7]  = '{1,1,3,2, 0,0,0,3'd0, 0, 0,0,19, 0,3'd0};
    tv[8]  = '{0,0,0,0, 0,0,0,3'd0, 0, 0,0,19, 0,3'd0};
    tv[9]  = '{0,0,0,0, 0,0,0,3'd0, 0, 0,0,19, 1,3'd5};
    tv[10] = '{0,0,0,0, 1,8,0,3'd7, 0, 0,1,19, 0,3'd0};
    tv[11] = '{1,0,3,2, 0,0,0,3'd0, 0, 0,0,19, 0,3'd0};
    tv[12] = '{0,0,0,0, 0,0,0,3'd0, 0, 0,0,19, 0,3'd0};
    tv[13] = '{0,0,0,0, 0,0,0,3'd0, 0, 0,0,19, 1,3'd0};
    for (int i = 0; i < N; i++) begin
      ram[i] = 3'($urandom);
      mram[i] = ram[i];
    end
    model_reset();
    #1;
    reset_n = 0;
    pix_en = 1; display_on = 1; hpos = 3; vpos = 1; wr_req = 1; wr_x = 1; clear_req = 1;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    reset_n = 1;
    for (int i = 0; i < 14; i++) begin
      pix_en = tv[i].pe; display_on = tv[i].don; hpos = 10'(tv[i].h); vpos = 10'(tv[i].v);
      wr_req = tv[i].wr; wr_x = 10'(tv[i].x); wr_y = 10'(tv[i].y); wr_rgb = tv[i].rgb;
      clear_req = tv[i].cr;
      settle();
      chk($sformatf("tv%0d_we", i), mem_we, tv[i].we);
      chk($sformatf("tv%0d_ack", i), wr_ack, tv[i].ack);
      chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].addr);
      if (tv[i].we) chk($sformatf("tv%0d_wdata", i), mem_wdata, tv[i].rgb);
      if (tv[i].pc) chk($sformatf("tv%0d_pix", i), pix_rgb, tv[i].pix);
      advance();
    end
    idle_inputs();
    clear_req = 1;
    settle();
    chk("clr_start_we", mem_we, 0);
    advance();
    clear_req = 0;
    for (int k = 0; k < N; k++) begin
      settle();
      chk("clr_busy", clear_busy, 1);
      chk("clr_we", mem_we, 1);
      chk("clr_addr", mem_addr, k);
      chk("clr_data", mem_wdata, CC);
      advance();
    end
    settle();
    chk("clr_done_busy", clear_busy, 0);
    chk("clr_done_we", mem_we, 0);
    advance();
    for (int i = 0; i < N + 2; i++) begin
      pix_en = i < N; display_on = i < N; hpos = 10'(i % H); vpos = 10'(i / H);
      settle();
      if (i >= 2) chk("scan_pix", pix_rgb, CC);
      advance();
    end
    idle_inputs();
    clear_req = 1; wr_req = 1; wr_x = 1; wr_y = 1; wr_rgb = 3'd7;
    settle();
    chk("cb_first_ack", wr_ack, 0);
    advance();
    clear_req = 0;
    begin
      bit found = 0;
      for (int n = 1; n < 100 && !found; n++) begin
        settle();
        if (wr_ack) begin
          found = 1;
          chk("cb_ack_cycle", n, 33);
          chk("cb_ack_busy", clear_busy, 0);
        end
        advance();
      end
      if (!found) chk("cb_ack_timeout", 0, 1);
    end
    wr_req = 0;
    clear_req = 1;
    cyc();
    clear_req = 0;
    repeat (10) cyc();
    pix_en = 1; display_on = 1; hpos = 5; vpos = 0; wr_req = 1; wr_x = 2; wr_y = 0; wr_rgb = 3'd6;
    #2;
    reset_n = 0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    pix_en = 0; display_on = 0;
    reset_n = 1;
    settle();
`ifndef FB_CLEAR_ON_RESET_EN
    chk("midrst_brush_ack", wr_ack, 1);
`endif
    advance();
    wr_req = 0;
    repeat (800) begin
      pix_en = 1'($urandom_range(0, 1));
      display_on = $urandom_range(0, 9) < 7;
      hpos = 10'(display_on ? $urandom_range(0, H - 1) : $urandom_range(0, 15));
      vpos = 10'(display_on ? $urandom_range(0, V - 1) : $urandom_range(0, 7));
      clear_req = $urandom_range(0, 59) == 0;
      if (m_last_ack) wr_req = 0;
      else if (!wr_req) begin
        wr_req = $urandom_range(0, 2) != 0;
        wr_x = 10'($urandom_range(0, H + 1));
        wr_y = 10'($urandom_range(0, V));
        wr_rgb = 3'($urandom);
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
